// File: rtl/cirno_fetch_pkg.sv
`default_nettype none
// ============================================================================
// cirno_fetch_pkg : shared widths, queue entry type and redirect encoding
// Rev 1.0
// ============================================================================
package cirno_fetch_pkg;

    localparam int PC_W   = 9;
    localparam int INST_W = 9;
    localparam int IMM_W  = 6;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RD_NONE    = 2'd0,
        RD_INIT    = 2'd1,
        RD_BRANCH  = 2'd2,
        RD_BRANCHI = 2'd3
    } redirect_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : ring-buffer prefetch queue with a registered head that holds
//              its last value once the queue drains. Rev 1.0
// ============================================================================
module fetch_fifo
    import cirno_fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output T                       head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    T              r_head;
    T              w_head_nxt;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] w_rd_p1;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop   = pop && (r_count != '0);
    assign w_rd_p1 = r_rd + AW'(1);

    // Head is a separate register so it can keep showing the last entry when empty.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_count > CW'(1)) begin
                w_head_nxt = r_mem[w_rd_p1];
            end else if (push) begin
                w_head_nxt = push_data;
            end
        end else if ((r_count == '0) && push) begin
            w_head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= w_rd_p1;
            end
            r_count <= r_count + CW'(push) - CW'(w_pop);
            r_head  <= w_head_nxt;
        end
    end

    assign count = r_count;
    assign head  = r_head;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit : PC, writable sync-read instruction ROM and prefetch queue
//                    feeding decode over valid/ready. Rev 1.0
// ============================================================================
module fetch_queue_unit #(
    parameter int              PC_W     = cirno_fetch_pkg::PC_W,
    parameter int              INST_W   = cirno_fetch_pkg::INST_W,
    parameter int              IMM_W    = cirno_fetch_pkg::IMM_W,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_unit_en,
    input  logic                    init,
    input  logic [PC_W-1:0]         start_address,
    input  logic                    branch,
    input  logic [PC_W-1:0]         target,
    input  logic                    branchi,
    input  logic [IMM_W-1:0]        immediate,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [INST_W-1:0]       inst,
    output logic [PC_W-1:0]         inst_pc,
    output logic [$clog2(QDEPTH):0] q_count,
    input  logic                    prog_we,
    input  logic [PC_W-1:0]         prog_addr,
    input  logic [INST_W-1:0]       prog_data
);

    import cirno_fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [INST_W-1:0] r_rom [2**PC_W];
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_if_pc;
    logic [INST_W-1:0] r_if_inst;
    logic              r_inflight;
    logic [PC_W-1:0]   w_imm_sext;
    logic [PC_W-1:0]   w_target;
    logic [CW-1:0]     w_count;
    logic              w_flush;
    logic              w_issue;
    logic              w_pop;
    redirect_e         w_redir;
    entry_t            w_head;
    entry_t            w_if_entry;

    generate
        if (PC_W > IMM_W) begin : g_sext_wide
            assign w_imm_sext = {{(PC_W-IMM_W){immediate[IMM_W-1]}}, immediate};
        end else begin : g_sext_narrow
            assign w_imm_sext = immediate[PC_W-1:0];
        end
    endgenerate

    // A relative branch needs a valid head to be relative to; otherwise it is dropped.
    always_comb begin
        w_redir = RD_NONE;
        if (init) begin
            w_redir = RD_INIT;
        end else if (branch) begin
            w_redir = RD_BRANCH;
        end else if (branchi && inst_valid) begin
            w_redir = RD_BRANCHI;
        end
    end

    always_comb begin
        w_target = r_pc;
        case (w_redir)
            RD_INIT:    w_target = start_address;
            RD_BRANCH:  w_target = target;
            RD_BRANCHI: w_target = w_head.pc + w_imm_sext;
            default:    w_target = r_pc;
        endcase
    end

    assign w_flush = (w_redir != RD_NONE);
    // Credit counts the in-flight read but ignores a same-cycle pop.
    assign w_issue = fetch_unit_en && !w_flush
                     && ((w_count + CW'(r_inflight)) < CW'(QDEPTH));
    assign w_pop   = inst_valid && inst_ready && !w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_if_pc    <= '0;
        end else if (w_flush) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc    <= r_pc + PC_W'(1);
                r_if_pc <= r_pc;
            end
        end
    end

    // Write and read share one block so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_rom[prog_addr] <= prog_data;
        end
        if (w_issue) begin
            r_if_inst <= r_rom[r_pc];
        end
    end

    assign w_if_entry.pc   = r_if_pc;
    assign w_if_entry.inst = r_if_inst;

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (w_if_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .count     (w_count),
        .head      (w_head)
    );

    assign inst_valid = (w_count != '0);
    assign q_count    = w_count;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue_unit : scenario tasks checked against a queue-based model
// Rev 1.0
// ============================================================================
module tb_fetch_queue_unit;

    localparam int PC_W   = 9;
    localparam int INST_W = 9;
    localparam int IMM_W  = 6;
    localparam int QDEPTH = 4;
    localparam int ROM_N  = 1 << PC_W;
    localparam int CW     = $clog2(QDEPTH) + 1;
    localparam int OW     = 1 + CW + INST_W + PC_W;

    logic              clk           = 1'b0;
    logic              rst_n         = 1'b0;
    logic              fetch_unit_en = 1'b0;
    logic              init          = 1'b0;
    logic              branch        = 1'b0;
    logic              branchi       = 1'b0;
    logic              inst_ready    = 1'b0;
    logic              prog_we       = 1'b0;
    logic [PC_W-1:0]   start_address = '0;
    logic [PC_W-1:0]   target        = '0;
    logic [PC_W-1:0]   prog_addr     = '0;
    logic [IMM_W-1:0]  immediate     = '0;
    logic [INST_W-1:0] prog_data     = '0;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic [CW-1:0]     q_count;
    logic [OW-1:0]     dut_out;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .PC_W(PC_W), .INST_W(INST_W), .IMM_W(IMM_W), .QDEPTH(QDEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_unit_en(fetch_unit_en),
        .init(init), .start_address(start_address),
        .branch(branch), .target(target),
        .branchi(branchi), .immediate(immediate),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .q_count(q_count),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    assign dut_out = {inst_valid, q_count, inst, inst_pc};

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t              m_q[$];
    ent_t              m_pend[$];
    ent_t              m_last;
    logic [PC_W-1:0]   m_pc;
    logic [INST_W-1:0] m_rom [ROM_N];
    int                n_vec = 0;
    int                n_bad = 0;

    function automatic logic [OW-1:0] m_out();
        return {m_q.size() != 0, CW'(m_q.size()), m_last.inst, m_last.pc};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend.delete();
        m_pc   = '0;
        m_last = '0;
    endtask

    // One clock of the architectural rules, using the inputs currently driven.
    task automatic model_step();
        ent_t            e;
        logic [PC_W-1:0] tgt;
        bit              redir;
        bit              issue;
        bit              vld;
        int              off;
        vld   = (m_q.size() != 0);
        redir = 1'b1;
        tgt   = m_pc;
        off   = $signed(immediate);
        if (init)                tgt = start_address;
        else if (branch)         tgt = target;
        else if (branchi && vld) tgt = PC_W'((int'(m_q[0].pc) + off + ROM_N) % ROM_N);
        else                     redir = 1'b0;
        if (redir) begin
            m_q.delete();
            m_pend.delete();
            m_pc = tgt;
        end else begin
            issue = fetch_unit_en && ((m_q.size() + m_pend.size()) < QDEPTH);
            if (vld && inst_ready) void'(m_q.pop_front());
            if (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
            if (issue) begin
                e.pc   = m_pc;
                e.inst = m_rom[m_pc];
                m_pend.push_back(e);
                m_pc = PC_W'((int'(m_pc) + 1) % ROM_N);
            end
        end
        if (prog_we) m_rom[prog_addr] = prog_data;
        if (m_q.size() != 0) m_last = m_q[0];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset.inst_valid got=%0b exp=0", inst_valid); end
        n_vec++; if (q_count !== '0) begin n_bad++; $display("FAIL reset.q_count got=%0d exp=0", q_count); end
        n_vec++; if (inst !== '0) begin n_bad++; $display("FAIL reset.inst got=%h exp=0", inst); end
        n_vec++; if (inst_pc !== '0) begin n_bad++; $display("FAIL reset.inst_pc got=%h exp=0", inst_pc); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_program();
        fetch_unit_en = 1'b0;
        inst_ready    = 1'b0;
        for (int a = 0; a < ROM_N; a++) begin
            prog_we   = 1'b1;
            prog_addr = PC_W'(a);
            prog_data = (a < 8) ? INST_W'(32'h100 + a) : INST_W'($urandom);
            tick();
        end
        prog_we = 1'b0;
        n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL program.idle got=%h exp=%h", dut_out, m_out()); end
    endtask

    task automatic test_stream();
        fetch_unit_en = 1'b1;
        inst_ready    = 1'b1;
        init          = 1'b1;
        start_address = '0;
        tick();
        init = 1'b0;
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream.flush got=%0b exp=0", inst_valid); end
        for (int k = 0; k < 9; k++) begin
            tick();
            n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL stream.model got=%h exp=%h", dut_out, m_out()); end
            n_vec++;
            if (k == 0) begin
                if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream.latency got=%0b exp=0", inst_valid); end
            end else if (inst_valid !== 1'b1 || inst_pc !== PC_W'(k - 1) || inst !== INST_W'(32'h100 + k - 1)) begin
                n_bad++;
                $display("FAIL stream.seq got=%0b/%h/%h exp=1/%h/%h", inst_valid, inst_pc, inst, PC_W'(k - 1), INST_W'(32'h100 + k - 1));
            end
        end
    endtask

    task automatic test_stall();
        ent_t held;
        held       = m_last;
        inst_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL stall.model got=%h exp=%h", dut_out, m_out()); end
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== held.pc || inst !== held.inst) begin
                n_bad++; $display("FAIL stall.hold got=%h/%h exp=%h/%h", inst_pc, inst, held.pc, held.inst);
            end
        end
        n_vec++; if (q_count !== CW'(QDEPTH)) begin n_bad++; $display("FAIL stall.full got=%0d exp=%0d", q_count, QDEPTH); end
        inst_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL release.model got=%h exp=%h", dut_out, m_out()); end
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== PC_W'(int'(held.pc) + 1 + j)) begin
                n_bad++; $display("FAIL release.seq got=%0b/%h exp=1/%h", inst_valid, inst_pc, PC_W'(int'(held.pc) + 1 + j));
            end
        end
    endtask

    task automatic test_branchi(input logic [PC_W-1:0] head_pc, input logic [IMM_W-1:0] imm,
                                input logic [PC_W-1:0] exp_pc);
        int waited;
        fetch_unit_en = 1'b1;
        inst_ready    = 1'b0;
        init          = 1'b1;
        start_address = head_pc;
        tick();
        init = 1'b0;
        tick();
        tick();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== head_pc) begin n_bad++; $display("FAIL branchi.head got=%0b/%h exp=1/%h", inst_valid, inst_pc, head_pc); end
        branchi    = 1'b1;
        immediate  = imm;
        inst_ready = 1'b1;
        tick();
        branchi = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || q_count !== '0) begin n_bad++; $display("FAIL branchi.flush got=%0b/%0d exp=0/0", inst_valid, q_count); end
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 6) begin
            tick();
            waited++;
        end
        n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL branchi.model got=%h exp=%h", dut_out, m_out()); end
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== exp_pc || waited != 2) begin
            n_bad++; $display("FAIL branchi.target got=%0b/%h after %0d exp=1/%h after 2", inst_valid, inst_pc, waited, exp_pc);
        end
    endtask

    task automatic test_priority();
        int waited;
        fetch_unit_en = 1'b1;
        inst_ready    = 1'b1;
        init          = 1'b1;
        branch        = 1'b1;
        branchi       = 1'b1;
        start_address = 9'h040;
        target        = 9'h080;
        immediate     = IMM_W'($urandom);
        tick();
        init = 1'b0; branch = 1'b0; branchi = 1'b0;
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 6) begin tick(); waited++; end
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 9'h040) begin n_bad++; $display("FAIL prio.init got=%0b/%h exp=1/040", inst_valid, inst_pc); end
        fetch_unit_en = 1'b0;
        init          = 1'b1;
        start_address = 9'h030;
        tick();
        init = 1'b0;
        tick();
        tick();
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL prio.empty got=%0b exp=0", inst_valid); end
        branchi   = 1'b1;
        immediate = 6'h05;
        tick();
        branchi = 1'b0;
        n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL prio.model got=%h exp=%h", dut_out, m_out()); end
        fetch_unit_en = 1'b1;
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 6) begin tick(); waited++; end
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 9'h030) begin n_bad++; $display("FAIL prio.branchi_ignored got=%0b/%h exp=1/030", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap_rbw();
        logic [INST_W-1:0] old3;
        logic [INST_W-1:0] new3;
        int                seen3;
        int                exp_pc;
        seen3         = 0;
        old3          = m_rom[3];
        new3          = old3 ^ 9'h0AA;
        fetch_unit_en = 1'b1;
        inst_ready    = 1'b1;
        init          = 1'b1;
        start_address = 9'h1FC;
        tick();
        init   = 1'b0;
        exp_pc = 'h1FC;
        for (int k = 1; k <= 14; k++) begin
            prog_we   = (k == 8);
            prog_addr = 9'h003;
            prog_data = new3;
            tick();
            n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL wrap.model got=%h exp=%h", dut_out, m_out()); end
            if (k >= 2) begin
                n_vec++;
                if (inst_valid !== 1'b1 || inst_pc !== PC_W'(exp_pc)) begin
                    n_bad++; $display("FAIL wrap.seq got=%0b/%h exp=1/%h", inst_valid, inst_pc, PC_W'(exp_pc));
                end
                exp_pc = (exp_pc + 1) % ROM_N;
            end
            if (inst_valid === 1'b1 && inst_pc === 9'h003) begin
                seen3++;
                n_vec++; if (inst !== old3) begin n_bad++; $display("FAIL rbw.old got=%h exp=%h", inst, old3); end
            end
        end
        prog_we = 1'b0;
        n_vec++; if (seen3 != 1) begin n_bad++; $display("FAIL rbw.seen got=%0d exp=1", seen3); end
        init          = 1'b1;
        start_address = 9'h003;
        tick();
        init = 1'b0;
        tick();
        tick();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 9'h003 || inst !== new3) begin n_bad++; $display("FAIL rbw.new got=%0b/%h/%h exp=1/003/%h", inst_valid, inst_pc, inst, new3); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            fetch_unit_en = ($urandom_range(0, 9) < 8);
            inst_ready    = ($urandom_range(0, 9) < 6);
            init          = ($urandom_range(0, 99) < 3);
            branch        = ($urandom_range(0, 99) < 3);
            branchi       = ($urandom_range(0, 99) < 6);
            start_address = PC_W'($urandom);
            target        = PC_W'($urandom);
            immediate     = IMM_W'($urandom);
            prog_we       = ($urandom_range(0, 99) < 5);
            prog_addr     = PC_W'($urandom);
            prog_data     = INST_W'($urandom);
            tick();
            n_vec++; if (dut_out !== m_out()) begin n_bad++; $display("FAIL random.model cyc=%0d got=%h exp=%h", c, dut_out, m_out()); end
        end
        init = 1'b0; branch = 1'b0; branchi = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_async_reset();
        int waited;
        fetch_unit_en = 1'b1;
        inst_ready    = 1'b0;
        init          = 1'b1;
        start_address = 9'h010;
        tick();
        init   = 1'b0;
        waited = 0;
        while (m_q.size() != 3 && waited < 8) begin tick(); waited++; end
        n_vec++; if (q_count !== CW'(3)) begin n_bad++; $display("FAIL areset.fill got=%0d exp=3", q_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (inst_valid !== 1'b0 || q_count !== '0 || inst !== '0 || inst_pc !== '0) begin
            n_bad++; $display("FAIL areset.immediate got=%0b/%0d/%h/%h exp=0/0/0/0", inst_valid, q_count, inst, inst_pc);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        waited     = 0;
        while (inst_valid !== 1'b1 && waited < 6) begin tick(); waited++; end
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== m_rom[0] || waited != 2) begin
            n_bad++; $display("FAIL areset.restart got=%0b/%h/%h after %0d exp=1/000/%h after 2", inst_valid, inst_pc, inst, waited, m_rom[0]);
        end
    endtask

    initial begin
        logic [PC_W-1:0]  hp;
        logic [IMM_W-1:0] im;
        int               off;
        test_reset();
        test_program();
        test_stream();
        test_stall();
        test_branchi(9'h005, 6'b111101, 9'h002);
        test_branchi(9'h1F0, 6'h1F, 9'h00F);
        hp  = PC_W'($urandom);
        im  = IMM_W'($urandom);
        off = $signed(im);
        test_branchi(hp, im, PC_W'((int'(hp) + off + ROM_N) % ROM_N));
        test_priority();
        test_wrap_rbw();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation instruction fetch stage for the cirno core.
- Owns the PC, a writable instruction ROM with synchronous read, and a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake, so decode stalls no longer lose fetches.
- Supports absolute, start and signed-relative redirects that flush all queued and in-flight work.

Parameters:
PC_W, 9, PC and ROM address width; ROM holds 2**PC_W words
INST_W, 9, instruction width
IMM_W, 6, relative-branch immediate width, two's-complement
QDEPTH, 4, prefetch queue entries, power of two, >=2
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_unit_en  in  1  permits new ROM reads; redirects are honoured regardless
init  in  1  redirect to start_address
start_address  in  PC_W  init target
branch  in  1  redirect to target
target  in  PC_W  absolute branch target
branchi  in  1  redirect to inst_pc + sext(immediate)
immediate  in  IMM_W  signed relative offset
inst_valid  out  1  queue head is valid
inst_ready  in  1  decode accepts the head
inst  out  INST_W  head instruction
inst_pc  out  PC_W  address of the head instruction
q_count  out  clog2(QDEPTH)+1  queue occupancy
prog_we  in  1  ROM write strobe
prog_addr  in  PC_W  ROM write address
prog_data  in  INST_W  ROM write data

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, queue empty, in-flight flag cleared.
  - Output reset values: inst_valid=0, q_count=0, inst=0, inst_pc=0.
  - ROM contents are not reset.
- Issue condition: fetch_unit_en=1 AND no redirect this cycle AND (q_count + inflight) < QDEPTH.
  - Credit check uses registered values only; a same-cycle pop does not add credit.
- Issue action: the ROM read of rom[pc] is registered together with pc; inflight<=1; pc<=pc+1, wrapping modulo 2**PC_W.
- Push: on the edge after an issue, the in-flight {pc, inst} enters the queue tail; inflight clears unless another issue occurs.
  - Queue never overflows, by construction of the credit check.
- Pop: when inst_valid && inst_ready. Push and pop in the same cycle leave q_count unchanged.
- Outputs: inst_valid = (q_count != 0). inst and inst_pc reflect the head. Outputs hold while inst_ready=0.
  - When the queue is empty, inst and inst_pc hold their last value.
- Redirect priority: init > branch > branchi.
  - branchi target = inst_pc + sign-extended immediate, modulo 2**PC_W.
  - branchi with inst_valid=0 is ignored: no flush, no PC change.
- Redirect action, at the edge of an accepted redirect:
  - Queue cleared, in-flight read discarded, pc<=target.
  - The pop is suppressed even if inst_ready=1.
  - No issue that cycle.
- Redirect latency: redirect at edge R -> read of target issued at R+1 (if enabled) -> inst_valid=1, inst_pc=target after R+2.
- Steady-state latency: 1 instruction per cycle when inst_ready=1 and fetch_unit_en=1. Issue-to-valid is 2 edges.
- fetch_unit_en=0: no new issues; an in-flight read still pushes; the queue still drains.
- ROM write: rom[prog_addr]<=prog_data at the edge.
  - A same-cycle read of the same address returns the old word (read-before-write).
  - No automatic flush: software issues init after programming.
- Reset mid-stream: everything in flight is lost immediately; state is as after power-up.

Decomposition:
- Package cirno_fetch_pkg holds:
  - default width constants: PC_W, INST_W, IMM_W;
  - typedef fetch_entry_t {pc, inst};
  - enum redirect_e {RD_NONE, RD_INIT, RD_BRANCH, RD_BRANCHI}.
- Sub-module fetch_fifo: parametrised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Async active-low reset.
  - Flush takes priority over push and pop.

Test Plan:
- Reset, ROM[0..7]=0x100+i, init start_address=0, inst_ready=1 -> inst_valid rises 2 edges after init; inst_pc 0,1,2,... with inst 0x100+i, one per cycle.
- inst_ready=0 for 10 cycles after streaming -> q_count saturates at 4; pc advances exactly 4 past the head; inst stays stable; on release, no gap or duplicate.
- Head inst_pc=5, branchi immediate=6'b111101 (-3) -> queue flushed same edge; next valid inst_pc=2. Repeat with immediate=6'h1F and inst_pc=0x1F0 -> target 0x00F, checking wrap.
- init, branch and branchi asserted together, with start_address=0x040 and target=0x080 -> next valid inst_pc=0x040. Then branchi with inst_valid=0 -> no effect.
- Fetch through pc=0x1FF -> next inst_pc=0x000. prog_we writing address 3 on the same edge a read of 3 issues -> old word delivered; the next fetch of 3 returns the new word.
- Deassert rst_n asynchronously mid-stream with q_count=3 -> inst_valid=0 and q_count=0 immediately, before the next edge; after release, pc=RESET_PC.
